// File: rtl/dac_stream_packer.sv
// Packs narrow AXI-Stream sample beats into wide DAC driver words, zero-padding
// short frame tails and reporting per-frame word counts.
module dac_stream_packer #(
    parameter int unsigned IN_WIDTH  = 64,
    parameter int unsigned OUT_WIDTH = 256,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [CNT_WIDTH-1:0] frame_words,
    output logic                 frame_done,
    output logic                 pad_flag
);

    localparam int unsigned RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(RATIO - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic                 run_q, run_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 out_pad_q, out_pad_d;
    logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_WIDTH-1:0] frame_words_q, frame_words_d;
    logic                 frame_done_q, frame_done_d;
    logic                 pad_flag_q, pad_flag_d;

    logic                 in_accept;
    logic                 out_accept;
    logic                 complete;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [OUT_WIDTH-1:0] merged;

    // Input is blocked until the cycle after reset releases, and while a held word is stalled.
    assign s_axis_tready = run_q && (!out_valid_q || m_axis_tready);
    assign in_accept     = s_axis_tvalid && s_axis_tready;
    assign out_accept    = out_valid_q && m_axis_tready;
    assign complete      = (idx_q == IDX_LAST) || s_axis_tlast;
    assign cnt_inc       = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + CNT_WIDTH'(1);

    // Accumulator with the incoming beat in lane idx; lanes above idx are zero.
    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (IDX_W'(i) == idx_q) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
            end else if (IDX_W'(i) < idx_q) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = acc_q[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // Next-state: packing, output hand-off and frame accounting.
    always_comb begin
        run_d         = 1'b1;
        idx_d         = idx_q;
        acc_d         = acc_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_pad_d     = out_pad_q;
        run_cnt_d     = run_cnt_q;
        frame_words_d = frame_words_q;
        frame_done_d  = 1'b0;
        pad_flag_d    = pad_flag_q;

        if (out_accept) begin
            out_valid_d = 1'b0;
        end

        if (in_accept) begin
            if (complete) begin
                out_data_d  = merged;
                out_valid_d = 1'b1;
                out_last_d  = s_axis_tlast;
                out_pad_d   = (idx_q != IDX_LAST);
                acc_d       = '0;
                idx_d       = '0;
            end else begin
                acc_d = merged;
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (out_accept) begin
            if (out_last_q) begin
                frame_words_d = cnt_inc;
                run_cnt_d     = '0;
                frame_done_d  = 1'b1;
                pad_flag_d    = out_pad_q;
            end else begin
                run_cnt_d = cnt_inc;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q         <= 1'b0;
            idx_q         <= '0;
            acc_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_pad_q     <= 1'b0;
            run_cnt_q     <= '0;
            frame_words_q <= '0;
            frame_done_q  <= 1'b0;
            pad_flag_q    <= 1'b0;
        end else begin
            run_q         <= run_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_pad_q     <= out_pad_d;
            run_cnt_q     <= run_cnt_d;
            frame_words_q <= frame_words_d;
            frame_done_q  <= frame_done_d;
            pad_flag_q    <= pad_flag_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign frame_words   = frame_words_q;
    assign frame_done    = frame_done_q;
    assign pad_flag      = pad_flag_q;

endmodule

// File: doc/dac_stream_packer.md
Name: dac_stream_packer

Overview:
- Width converter directly upstream of the DAC driver's 256-bit PS input port.
- Accepts 64-bit AXI-Stream beats (4 × 16-bit samples) from the PS DMA and packs them into 256-bit words (16 samples).
- Emits the packed words to the driver, which writes them into its waveform FIFO.
- Zero-pads a partial final word when a frame ends early, and reports per-frame word counts for software.

Parameters:
- IN_WIDTH, 64, input beat width in bits; multiple of 16.
- OUT_WIDTH, 256, output word width in bits; OUT_WIDTH/IN_WIDTH (RATIO) must be a power of two, ≥2.
- CNT_WIDTH, 16, width of frame word counters.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset: synchronous, active-low.
- s_axis_tdata  in  IN_WIDTH  input samples; sample 0 in bits [15:0].
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of frame.
- m_axis_tdata  out  OUT_WIDTH  packed word to the DAC driver.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last word of frame.
- frame_words  out  CNT_WIDTH  output-word count of the most recently completed frame.
- frame_done  out  1  one-cycle pulse when a frame's last word is accepted downstream.
- pad_flag  out  1  sticky: the last completed frame ended on a partial word; cleared at the next frame_done without padding.

Behaviour:
- Reset (rst=0 at clk edge):
  - idx=0; accumulator=0; output register cleared.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=0 during reset, 1 the cycle after reset releases.
  - frame_words=0, frame_done=0, pad_flag=0; running word counter=0.
- Reset mid-frame discards the partial accumulator and any held output word. No output is emitted for discarded data.
- Storage: one accumulator (RATIO lanes) + one output holding register. idx counts 0..RATIO-1.
- s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational). Output accepted = m_axis_tvalid && m_axis_tready.
- Input accepted when s_axis_tvalid && s_axis_tready. On an accepted beat:
  - Lane idx (bits [idx*IN_WIDTH +: IN_WIDTH]) takes s_axis_tdata.
  - If idx==RATIO-1 or s_axis_tlast=1:
    - The output register loads the completed word.
    - Lanes above idx are forced to 0.
    - m_axis_tvalid=1 next cycle; m_axis_tlast = s_axis_tlast.
    - idx←0; accumulator cleared.
  - Otherwise idx←idx+1.
- Latency: output word valid on the cycle after the completing input beat is accepted.
- Throughput: sustained 1 input beat/cycle with m_axis_tready held high; one output word every RATIO cycles.
- Backpressure:
  - While the output is held and m_axis_tready=0: s_axis_tready=0, and m_axis_tdata/m_axis_tlast stay stable until accepted.
  - Same-cycle output accept and new completing beat: the output register reloads, m_axis_tvalid stays 1, and no bubble is inserted.
- Counting:
  - The running counter increments on each accepted output word.
  - On an accepted word with m_axis_tlast=1:
    - frame_words ← running+1; running ← 0.
    - frame_done=1 for one cycle.
    - pad_flag ← 1 if that word was padded (tlast arrived at idx<RATIO-1), else 0.
- Counter wrap: the running counter saturates at 2^CNT_WIDTH−1; it does not wrap.
- tlast on idx==RATIO-1 is not padded (pad_flag=0).
- s_axis_tlast on a beat with s_axis_tvalid=0 is ignored.

Test Plan:
- Reset then 8 beats, tdata=beat index n replicated in all 4 samples, tlast on beat 7, m_axis_tready=1:
  - 2 words out.
  - Word0 lanes = 0,1,2,3; word1 lanes = 4,5,6,7; word1 tlast=1.
  - frame_words=2, frame_done one pulse, pad_flag=0.
  - Each word valid 1 cycle after beats 3 and 7.
- 6 beats, values 0x1111..0x6666 per sample, tlast on beat 5:
  - Word1 lanes = 0x5555, 0x6666, 0, 0; tlast=1.
  - frame_words=2, pad_flag=1.
- Single-beat frame (tlast on the first beat, data 0xABCD):
  - One word with lane0=0xABCD…, lanes1–3 = 0; tlast=1.
  - frame_words=1, pad_flag=1.
- 16 beats continuous, m_axis_tready=0 for 10 cycles after the first word is valid:
  - s_axis_tready=0 throughout the stall; word0 data stable.
  - No beats lost; 4 words in order; total 16 input accepts.
- Reset asserted after beat 2 of a frame, then a fresh 4-beat frame with tlast:
  - No output from the discarded partial.
  - The new frame yields exactly one word.
  - frame_words=1, pad_flag=0.
- Full-throughput check, 400 beats at tvalid=1, m_axis_tready=1:
  - 100 words, one every 4 cycles; s_axis_tready never drops.
